// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 16-bit core's IF/ID and ID/EX buffers.
// Optional macro HAZ_STATS_EN adds saturating stall_cycles/flush_count counters.
module pipe_hazard_ctrl #(
  parameter int REG_W    = 4,
  parameter int LOAD_LAT = 1,
  parameter int MUL_LAT  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs_a,
  input  logic [REG_W-1:0] id_rs_b,
  input  logic             id_uses_b,
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_dest,
  input  logic             ex_mul_start,
  input  logic             ex_branch_taken,
  output logic             pc_stall,
  output logic             ifid_hazard,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             idex_hold,
`ifdef HAZ_STATS_EN
  output logic [15:0]      stall_cycles,
  output logic [7:0]       flush_count,
`endif
  output logic [1:0]       ctrl_state
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MUL_WAIT   = 2'd2,
    ILLEGAL    = 2'd3
  } state_e;

  localparam bit         LOAD_MULTI = (LOAD_LAT > 1);
  localparam logic [3:0] LOAD_INIT  = LOAD_MULTI ? 4'(LOAD_LAT - 2) : 4'd0;
  localparam logic [3:0] MUL_INIT   = 4'(MUL_LAT - 2);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic lu;
  logic stall_c, haz_c, flush_c, bubble_c, hold_c;

  assign lu = ex_valid & ex_mem_read & id_valid & (ex_dest != '0) &
              ((ex_dest == id_rs_a) | (id_uses_b & (ex_dest == id_rs_b)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall_c  = 1'b0;
    haz_c    = 1'b0;
    flush_c  = 1'b0;
    bubble_c = 1'b0;
    hold_c   = 1'b0;
    case (state_q)
      RUN: begin
        if (ex_branch_taken) begin
          flush_c  = 1'b1;
          bubble_c = 1'b1;
        end else if (ex_mul_start) begin
          stall_c = 1'b1;
          haz_c   = 1'b1;
          hold_c  = 1'b1;
          cnt_d   = MUL_INIT;
          state_d = MUL_WAIT;
        end else if (lu) begin
          stall_c  = 1'b1;
          haz_c    = 1'b1;
          bubble_c = 1'b1;
          if (LOAD_MULTI) begin
            cnt_d   = LOAD_INIT;
            state_d = LOAD_STALL;
          end
        end
      end
      // EX holds a bubble here, so a branch indication cannot be genuine.
      LOAD_STALL: begin
        stall_c  = 1'b1;
        haz_c    = 1'b1;
        bubble_c = 1'b1;
        if (cnt_q == 4'd0) state_d = RUN;
        else               cnt_d   = cnt_q - 4'd1;
      end
      MUL_WAIT: begin
        stall_c = 1'b1;
        haz_c   = 1'b1;
        hold_c  = 1'b1;
        if (cnt_q == 4'd0) state_d = RUN;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: begin
        state_d = RUN;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Gate with reset so the controls drop the instant reset is asserted.
  assign pc_stall    = reset & stall_c;
  assign ifid_hazard = reset & haz_c;
  assign ifid_flush  = reset & flush_c;
  assign idex_bubble = reset & bubble_c;
  assign idex_hold   = reset & hold_c;
  assign ctrl_state  = state_q;

`ifdef HAZ_STATS_EN
  logic [15:0] stall_cycles_q;
  logic [7:0]  flush_count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles_q <= 16'd0;
      flush_count_q  <= 8'd0;
    end else begin
      if (pc_stall && stall_cycles_q != 16'hFFFF) stall_cycles_q <= stall_cycles_q + 16'd1;
      if (ifid_flush && flush_count_q != 8'hFF)   flush_count_q  <= flush_count_q + 8'd1;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`endif

  a_flush_hazard_excl: assert property (@(posedge clk) disable iff (!reset)
    !(ifid_flush && ifid_hazard));
  a_bubble_hold_excl: assert property (@(posedge clk) disable iff (!reset)
    !(idex_bubble && idex_hold));

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench: two controllers (LOAD_LAT=1 and LOAD_LAT=3) share stimulus;
// expected vectors are queued per cycle and checked by a separate monitor.
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic id_valid = 1'b0, id_uses_b = 1'b0, ex_valid = 1'b0, ex_mem_read = 1'b0;
  logic ex_mul_start = 1'b0, ex_branch_taken = 1'b0;
  logic [3:0] id_rs_a = 4'd0, id_rs_b = 4'd0, ex_dest = 4'd0;

  logic s1, h1, f1, b1, k1, s3, h3, f3, b3, k3;
  logic [1:0] st1, st3;
`ifdef HAZ_STATS_EN
  logic [15:0] sc1, sc3;
  logic [7:0]  fc1, fc3;
`endif

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_W(4), .LOAD_LAT(1), .MUL_LAT(4)) u1 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs_a(id_rs_a), .id_rs_b(id_rs_b),
    .id_uses_b(id_uses_b), .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_dest(ex_dest),
    .ex_mul_start(ex_mul_start), .ex_branch_taken(ex_branch_taken),
    .pc_stall(s1), .ifid_hazard(h1), .ifid_flush(f1), .idex_bubble(b1), .idex_hold(k1),
`ifdef HAZ_STATS_EN
    .stall_cycles(sc1), .flush_count(fc1),
`endif
    .ctrl_state(st1));

  pipe_hazard_ctrl #(.REG_W(4), .LOAD_LAT(3), .MUL_LAT(4)) u3 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs_a(id_rs_a), .id_rs_b(id_rs_b),
    .id_uses_b(id_uses_b), .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_dest(ex_dest),
    .ex_mul_start(ex_mul_start), .ex_branch_taken(ex_branch_taken),
    .pc_stall(s3), .ifid_hazard(h3), .ifid_flush(f3), .idex_bubble(b3), .idex_hold(k3),
`ifdef HAZ_STATS_EN
    .stall_cycles(sc3), .flush_count(fc3),
`endif
    .ctrl_state(st3));

  // {pc_stall, ifid_hazard, ifid_flush, idex_bubble, idex_hold, ctrl_state[1:0]}
  localparam logic [6:0] IDLE  = 7'b00000_00;
  localparam logic [6:0] FLUSH = 7'b00110_00;
  localparam logic [6:0] LU_R  = 7'b11010_00;
  localparam logic [6:0] LU_S  = 7'b11010_01;
  localparam logic [6:0] MUL_R = 7'b11001_00;
  localparam logic [6:0] MUL_W = 7'b11001_10;

  typedef struct {
    string      nm;
    logic [6:0] e1;
    logic [6:0] e3;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  wire [6:0] o1 = {s1, h1, f1, b1, k1, st1};
  wire [6:0] o3 = {s3, h3, f3, b3, k3, st3};

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (o1 !== e.e1) begin
        errors++;
        $display("FAIL %s lat1: got %b want %b", e.nm, o1, e.e1);
      end
      checks++;
      if (o3 !== e.e3) begin
        errors++;
        $display("FAIL %s lat3: got %b want %b", e.nm, o3, e.e3);
      end
      $display("cycle %-10s lat1=%b lat3=%b", e.nm, o1, o3);
    end
  end

  task automatic cyc(input string nm, input logic rst, input logic idv,
                     input logic [3:0] rsa, input logic [3:0] rsb, input logic ub,
                     input logic exv, input logic mr, input logic [3:0] dest,
                     input logic mul, input logic br,
                     input logic [6:0] x1, input logic [6:0] x3);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; id_valid = idv; id_rs_a = rsa; id_rs_b = rsb; id_uses_b = ub;
    ex_valid = exv; ex_mem_read = mr; ex_dest = dest;
    ex_mul_start = mul; ex_branch_taken = br;
    e.nm = nm; e.e1 = x1; e.e3 = x3;
    sb.push_back(e);
  endtask

  initial begin
    //   name          rst idv rsa  rsb  ub exv mr dest mul br   lat1   lat3
    cyc("rst_a",       0,  1,  3,   0,   0, 1,  1, 3,   0,  1,   IDLE,  IDLE);
    cyc("rst_b",       0,  1,  3,   0,   0, 1,  1, 3,   0,  1,   IDLE,  IDLE);
    cyc("rel_flush",   1,  1,  3,   0,   0, 1,  1, 3,   0,  1,   FLUSH, FLUSH);
    cyc("idle",        1,  0,  0,   0,   0, 0,  0, 0,   0,  0,   IDLE,  IDLE);
    cyc("lu_a0",       1,  1,  3,   0,   0, 1,  1, 3,   0,  0,   LU_R,  LU_R);
    cyc("lu_a1",       1,  0,  0,   0,   0, 0,  0, 0,   0,  0,   IDLE,  LU_S);
    cyc("lu_a2",       1,  0,  0,   0,   0, 0,  0, 0,   0,  0,   IDLE,  LU_S);
    cyc("lu_a3",       1,  0,  0,   0,   0, 0,  0, 0,   0,  0,   IDLE,  IDLE);
    cyc("r0_nohaz",    1,  1,  0,   0,   0, 1,  1, 0,   0,  0,   IDLE,  IDLE);
    cyc("lu_b0",       1,  1,  0,   5,   1, 1,  1, 5,   0,  0,   LU_R,  LU_R);
    cyc("lu_b1_br",    1,  0,  0,   0,   0, 1,  0, 0,   0,  1,   FLUSH, LU_S);
    cyc("lu_b2",       1,  0,  0,   0,   0, 0,  0, 0,   0,  0,   IDLE,  LU_S);
    cyc("lu_b3",       1,  0,  0,   0,   0, 0,  0, 0,   0,  0,   IDLE,  IDLE);
    cyc("nouse_b",     1,  1,  0,   5,   0, 1,  1, 5,   0,  0,   IDLE,  IDLE);
    cyc("mul0",        1,  0,  0,   0,   0, 1,  0, 0,   1,  0,   MUL_R, MUL_R);
    cyc("mul1",        1,  0,  0,   0,   0, 0,  0, 0,   0,  0,   MUL_W, MUL_W);
    cyc("mul2",        1,  0,  0,   0,   0, 0,  0, 0,   0,  0,   MUL_W, MUL_W);
    cyc("mul3",        1,  0,  0,   0,   0, 0,  0, 0,   0,  0,   MUL_W, MUL_W);
    cyc("mul_done",    1,  0,  0,   0,   0, 0,  0, 0,   0,  0,   IDLE,  IDLE);
    cyc("br_lu",       1,  1,  7,   0,   0, 1,  1, 7,   0,  1,   FLUSH, FLUSH);
    cyc("br_mul",      1,  0,  0,   0,   0, 1,  0, 0,   1,  1,   FLUSH, FLUSH);
    cyc("after_bm",    1,  0,  0,   0,   0, 0,  0, 0,   0,  0,   IDLE,  IDLE);
    cyc("mrst0",       1,  0,  0,   0,   0, 1,  0, 0,   1,  0,   MUL_R, MUL_R);
    cyc("mrst1",       1,  0,  0,   0,   0, 0,  0, 0,   0,  0,   MUL_W, MUL_W);
    cyc("mrst_low0",   0,  0,  0,   0,   0, 0,  0, 0,   0,  0,   IDLE,  IDLE);
    cyc("mrst_low1",   0,  0,  0,   0,   0, 0,  0, 0,   0,  0,   IDLE,  IDLE);
    cyc("mrst_rel",    1,  0,  0,   0,   0, 0,  0, 0,   0,  0,   IDLE,  IDLE);
`ifdef HAZ_STATS_EN
    @(posedge clk);
    #2;
    checks++;
    if (sc1 !== 16'd0 || sc3 !== 16'd0) begin
      errors++;
      $display("FAIL stall_cycles_after_rst: got %0d/%0d want 0", sc1, sc3);
    end
`endif
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
